// File: rtl/axi2mem_b_resp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi2mem_b_resp_gen
//  Description : AXI write-response (B channel) generator for axi2mem.
//                Keeps an in-order table of accepted AW bursts (ID/USER).
//                An entry is marked complete when the memory side commits
//                the last W beat of that burst. Completed entries are
//                returned as B responses in AW acceptance order.
//  Ports       : clk_i, rst_ni         clock / async active-low reset
//                aw_push_i/id/user     AW burst accepted (one-cycle pulse)
//                aw_full_o             table full, do not accept more AWs
//                w_last_i/w_err_i      last W beat of oldest open burst
//                b_valid_o/id/resp/user, b_ready_i   AXI B channel
//                proto_err_o           sticky protocol-violation flag
//  Revision    : 1.0  initial release
// ============================================================================
module axi2mem_b_resp_gen #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 6,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_push_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    output logic                  aw_full_o,
    input  logic                  w_last_i,
    input  logic                  w_err_i,
    output logic                  b_valid_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i,
    output logic                  proto_err_o
);

    localparam int unsigned          c_IDX_W   = $clog2(DEPTH);
    localparam int unsigned          c_PTR_W   = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]   c_DEPTH   = c_PTR_W'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_done_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;

    logic [ID_WIDTH-1:0]   r_id   [DEPTH];
    logic [USER_WIDTH-1:0] r_user [DEPTH];
    logic                  r_done [DEPTH];
    logic                  r_err  [DEPTH];
    logic                  r_proto_err;

    logic [c_PTR_W-1:0]    w_occupancy;
    logic                  w_full;
    logic                  w_open_any;
    logic                  w_head_pending;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_cmpl;
    logic                  w_pop;
    logic                  w_push_err;
    logic                  w_cmpl_err;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_done_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;

    assign w_wr_idx   = r_wr_ptr[c_IDX_W-1:0];
    assign w_done_idx = r_done_ptr[c_IDX_W-1:0];
    assign w_rd_idx   = r_rd_ptr[c_IDX_W-1:0];

    // Full is based on registered pointers only: a pop in the same cycle
    // does not free a slot for a same-cycle push.
    assign w_occupancy    = r_wr_ptr - r_rd_ptr;
    assign w_full         = (w_occupancy == c_DEPTH);
    assign w_open_any     = (r_done_ptr != r_wr_ptr);
    assign w_head_pending = (r_rd_ptr != r_done_ptr);

    // The head done bit is always set whenever rd_ptr != done_ptr; it is
    // included so the valid term reflects the entry's own state as well.
    assign w_valid = w_head_pending & r_done[w_rd_idx];

    // Completion eligibility uses pre-edge pointers, so a burst pushed in
    // the same cycle cannot be completed by that cycle's w_last.
    assign w_push     = aw_push_i & ~w_full;
    assign w_push_err = aw_push_i &  w_full;
    assign w_cmpl     = w_last_i  &  w_open_any;
    assign w_cmpl_err = w_last_i  & ~w_open_any;
    assign w_pop      = w_valid   &  b_ready_i;

    // Push, complete and pop always target distinct slots: push is blocked
    // when the table is full, completion needs an open entry, and pop needs
    // a completed one, so no two of them can alias onto the same index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_done_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_id[i]   <= '0;
                r_user[i] <= '0;
                r_done[i] <= 1'b0;
                r_err[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_id[w_wr_idx]   <= aw_id_i;
                r_user[w_wr_idx] <= aw_user_i;
                r_done[w_wr_idx] <= 1'b0;
                r_err[w_wr_idx]  <= 1'b0;
                r_wr_ptr         <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_cmpl) begin
                r_done[w_done_idx] <= 1'b1;
                r_err[w_done_idx]  <= w_err_i;
                r_done_ptr         <= r_done_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_done[w_rd_idx] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push_err || w_cmpl_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // All outputs are decoded from registers only; payload is zeroed while
    // no response is offered. The head entry is untouched until popped, so
    // the payload holds steady under backpressure.
    assign aw_full_o   = w_full;
    assign b_valid_o   = w_valid;
    assign b_id_o      = w_valid ? r_id[w_rd_idx]            : '0;
    assign b_user_o    = w_valid ? r_user[w_rd_idx]          : '0;
    assign b_resp_o    = w_valid ? {r_err[w_rd_idx], 1'b0}   : 2'b00;
    assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axi2mem_b_resp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi2mem_b_resp_gen
//  Description : Self-checking bench for axi2mem_b_resp_gen. A queue-based
//                reference model (open bursts, completed bursts) predicts
//                B channel, full and protocol-error outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi2mem_b_resp_gen;

    localparam int ID_W   = 4;
    localparam int USER_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              aw_push = 1'b0;
    logic [ID_W-1:0]   aw_id = '0;
    logic [USER_W-1:0] aw_user = '0;
    logic              aw_full;
    logic              w_last = 1'b0;
    logic              w_err = 1'b0;
    logic              b_valid;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic [USER_W-1:0] b_user;
    logic              b_ready = 1'b0;
    logic              proto_err;

    axi2mem_b_resp_gen #(
        .ID_WIDTH   (ID_W),
        .USER_WIDTH (USER_W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .aw_push_i   (aw_push),
        .aw_id_i     (aw_id),
        .aw_user_i   (aw_user),
        .aw_full_o   (aw_full),
        .w_last_i    (w_last),
        .w_err_i     (w_err),
        .b_valid_o   (b_valid),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .b_user_o    (b_user),
        .b_ready_i   (b_ready),
        .proto_err_o (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [USER_W-1:0] user;
        logic              err;
    } ent_t;

    ent_t m_open[$];
    ent_t m_done[$];
    bit   m_proto;
    int   m_pops;
    int   n_checks;
    int   n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open.delete();
        m_done.delete();
        m_proto = 1'b0;
    endtask

    task automatic compare_outputs();
        bit   exp_valid;
        bit   exp_full;
        ent_t h;
        exp_valid = (m_done.size() > 0);
        exp_full  = ((m_open.size() + m_done.size()) == DEPTH);
        check_eq("b_valid", 32'(b_valid), 32'(exp_valid));
        check_eq("aw_full", 32'(aw_full), 32'(exp_full));
        check_eq("proto_err", 32'(proto_err), 32'(m_proto));
        if (exp_valid) begin
            h = m_done[0];
            check_eq("b_id", 32'(b_id), 32'(h.id));
            check_eq("b_user", 32'(b_user), 32'(h.user));
            check_eq("b_resp", 32'(b_resp), 32'({h.err, 1'b0}));
        end else begin
            check_eq("b_idle_payload", {b_id, b_user, b_resp}, 32'(0));
        end
    endtask

    // Reference model step using pre-edge state for every decision.
    task automatic model_clock(input bit push, input logic [ID_W-1:0] id,
                               input logic [USER_W-1:0] user, input bit wl,
                               input bit err, input bit rdy);
        bit   full_pre;
        bit   valid_pre;
        int   open_pre;
        ent_t e;
        full_pre  = ((m_open.size() + m_done.size()) == DEPTH);
        valid_pre = (m_done.size() > 0);
        open_pre  = m_open.size();
        if (valid_pre && rdy) begin
            void'(m_done.pop_front());
            m_pops++;
        end
        if (wl) begin
            if (open_pre > 0) begin
                e = m_open.pop_front();
                e.err = err;
                m_done.push_back(e);
            end else begin
                m_proto = 1'b1;
            end
        end
        if (push) begin
            if (full_pre) begin
                m_proto = 1'b1;
            end else begin
                e.id = id; e.user = user; e.err = 1'b0;
                m_open.push_back(e);
            end
        end
    endtask

    // Called at posedge+1: drive inputs, check outputs, clock, update model.
    task automatic cycle(input bit push, input logic [ID_W-1:0] id,
                         input logic [USER_W-1:0] user, input bit wl,
                         input bit err, input bit rdy);
        aw_push = push; aw_id = id; aw_user = user;
        w_last = wl; w_err = err; b_ready = rdy;
        compare_outputs();
        @(posedge clk);
        model_clock(push, id, user, wl, err, rdy);
        #1;
        aw_push = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    // Asynchronous reset assertion away from the clock edge; outputs must
    // clear immediately, before any further clock edge.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_b_valid", 32'(b_valid), 32'(0));
        check_eq("rst_aw_full", 32'(aw_full), 32'(0));
        check_eq("rst_proto_err", 32'(proto_err), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_pops   = 0;
        model_reset();

        // Reset state
        do_reset();
        idle(1, 1'b0);

        // Basic single burst: latency and payload
        cycle(1'b1, 4'd3, 6'd5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("latency_valid", 32'(b_valid), 32'(1));
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Fill to full, overflow push, then complete with mixed errors
        for (int i = 1; i <= 4; i++) cycle(1'b1, ID_W'(i), USER_W'(i + 8), 1'b0, 1'b0, 1'b0);
        check_eq("full_after_4", 32'(aw_full), 32'(1));
        cycle(1'b1, 4'd9, 6'd9, 1'b0, 1'b0, 1'b0);
        check_eq("overflow_proto", 32'(proto_err), 32'(1));
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'(i % 2), 1'b0);
        idle(6, 1'b1);
        check_eq("overflow_drained", 32'(m_pops), 32'(5));

        // Backpressure with traffic arriving while the head is held
        do_reset();
        cycle(1'b1, 4'd7, 6'd17, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd8, 6'd18, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle((i < 2), ID_W'(10 + i), USER_W'(20 + i), (i == 1 || i == 3), 1'b0, 1'b0);
        end
        check_eq("bp_no_pop", 32'(m_pops), 32'(5));
        idle(6, 1'b1);

        // Same-cycle push + complete + pop
        do_reset();
        cycle(1'b1, 4'd1, 6'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 6'd2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'd3, 6'd3, 1'b1, 1'b1, 1'b1);
        check_eq("same_cycle_no_proto", 32'(proto_err), 32'(0));
        idle(2, 1'b1);

        // w_last together with a push into an empty table
        do_reset();
        cycle(1'b1, 4'd4, 6'd4, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        check_eq("empty_wlast_proto", 32'(proto_err), 32'(1));
        check_eq("pushed_not_done", 32'(b_valid), 32'(0));

        // Random wrap run: 10 bursts through the table
        do_reset();
        m_pops = 0;
        begin
            int issued;
            int budget;
            issued = 0;
            budget = 0;
            while (m_pops < 10 && budget < 400) begin
                bit p;
                bit wl;
                p  = (issued < 10) && ((m_open.size() + m_done.size()) < DEPTH) && ($urandom_range(1, 0) == 1);
                wl = (m_open.size() > 0) && ($urandom_range(2, 0) == 0);
                cycle(p, ID_W'(issued % 16), USER_W'($urandom), wl, 1'($urandom), 1'($urandom));
                if (p) issued++;
                budget++;
            end
            check_eq("wrap_all_returned", 32'(m_pops), 32'(10));
            check_eq("wrap_no_proto", 32'(proto_err), 32'(0));
        end

        // Mid-operation reset: table full, two entries done, proto set
        for (int i = 0; i < 4; i++) cycle(1'b1, ID_W'(i), USER_W'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd15, 6'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("pre_reset_valid", 32'(b_valid), 32'(1));
        check_eq("pre_reset_full", 32'(aw_full), 32'(1));
        do_reset();
        idle(3, 1'b1);
        check_eq("post_reset_empty", 32'(b_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
